// File: rtl/data_memory_ctrl_pkg.sv
// data_memory_ctrl_pkg: access codes, fault codes and FSM states shared by the data memory.
package data_memory_ctrl_pkg;
    localparam logic [1:0] MEM_SB  = 2'd0;
    localparam logic [1:0] MEM_SH  = 2'd1;
    localparam logic [1:0] MEM_SW  = 2'd2;
    localparam logic [2:0] MEM_LB  = 3'd0;
    localparam logic [2:0] MEM_LH  = 3'd1;
    localparam logic [2:0] MEM_LW  = 3'd2;
    localparam logic [2:0] MEM_LBU = 3'd4;
    localparam logic [2:0] MEM_LHU = 3'd5;
    typedef enum logic [1:0] {
        MEM_FAULT_NONE     = 2'd0,
        MEM_FAULT_MISALIGN = 2'd1,
        MEM_FAULT_RANGE    = 2'd2,
        MEM_FAULT_FUNC     = 2'd3
    } fault_e;
    typedef enum logic {S_INIT, S_READY} state_e;
endpackage

// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: request/response bus between the load/store stage and the data memory.
interface data_memory_ctrl_if import data_memory_ctrl_pkg::*; ();
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_func_in;
    logic [2:0]  req_func_out;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    fault_e      rsp_fault_code;
    logic        init_done;
    modport master (
        output req_valid, req_we, req_func_in, req_func_out, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_fault, rsp_fault_code, init_done
    );
    modport slave (
        input  req_valid, req_we, req_func_in, req_func_out, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_fault, rsp_fault_code, init_done
    );
endinterface

// File: rtl/data_memory_ctrl_align.sv
// data_mem_align: store lane enables/replication, load extraction/extension and fault classification.
module data_mem_align import data_memory_ctrl_pkg::*; (
    input  logic        i_we,
    input  logic [1:0]  i_func_in,
    input  logic [2:0]  i_func_out,
    input  logic [1:0]  i_off,
    input  logic        i_range,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wlane,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output fault_e      o_code
);
    logic [15:0] w_sh;
    logic        w_half;
    logic        w_word;
    logic        w_bad;
    logic        w_mis;
    always_comb begin
        w_sh    = 16'(i_rword >> {i_off, 3'b000});
        w_half  = i_we ? (i_func_in == MEM_SH) : (i_func_out == MEM_LH || i_func_out == MEM_LHU);
        w_word  = i_we ? (i_func_in == MEM_SW) : (i_func_out == MEM_LW);
        w_bad   = i_we ? (i_func_in == 2'd3) : !(i_func_out inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU});
        w_mis   = (w_half && i_off[0]) || (w_word && i_off != 2'd0);
        o_code  = i_range ? MEM_FAULT_RANGE : w_bad ? MEM_FAULT_FUNC : w_mis ? MEM_FAULT_MISALIGN : MEM_FAULT_NONE;
        o_fault = o_code != MEM_FAULT_NONE;
        o_be    = i_func_in == MEM_SB ? 4'b0001 << i_off : i_func_in == MEM_SH ? 4'b0011 << i_off : 4'hF;
        o_wlane = i_func_in == MEM_SB ? {4{i_wdata[7:0]}} : i_func_in == MEM_SH ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata = (i_we || o_fault) ? 32'h0 :
                  i_func_out == MEM_LB  ? {{24{w_sh[7]}}, w_sh[7:0]} :
                  i_func_out == MEM_LH  ? {{16{w_sh[15]}}, w_sh} :
                  i_func_out == MEM_LBU ? {24'h0, w_sh[7:0]} :
                  i_func_out == MEM_LHU ? {16'h0, w_sh} : i_rword;
    end
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed RV32 data memory with zero-fill FSM and fixed-latency responses.
module data_memory_ctrl import data_memory_ctrl_pkg::*; #(
    parameter int DEPTH_WORDS    = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic               i_clk,
    input logic               i_rst_n,
    data_memory_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_e        r_state;
    logic [AW-1:0] r_cnt;
    logic          r_ready;
    logic          r_v [2];
    logic [31:0]   r_d [2];
    fault_e        r_c [2];
    logic          w_acc;
    logic          w_range;
    logic          w_clr;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_widx;
    logic [3:0]    w_be;
    logic [3:0]    w_we;
    logic [31:0]   w_wlane;
    logic [31:0]   w_wd;
    logic [31:0]   w_rword;
    logic [31:0]   w_rdata;
    logic          w_fault;
    fault_e        w_code;
    always_comb begin
        w_acc   = bus.req_valid & r_ready;
        w_range = |bus.req_addr[31:AW+2];
        w_idx   = bus.req_addr[AW+1:2];
        w_clr   = (r_state == S_INIT) && (CLEAR_ON_RESET != 0);
        w_we    = w_clr ? 4'hF : (w_acc && bus.req_we && !w_fault) ? w_be : 4'h0;
        w_widx  = w_clr ? r_cnt : w_idx;
        w_wd    = w_clr ? 32'h0 : w_wlane;
    end
    data_mem_align u_align (
        .i_we       (bus.req_we),
        .i_func_in  (bus.req_func_in),
        .i_func_out (bus.req_func_out),
        .i_off      (bus.req_addr[1:0]),
        .i_range    (w_range),
        .i_wdata    (bus.req_wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wlane    (w_wlane),
        .o_rdata    (w_rdata),
        .o_fault    (w_fault),
        .o_code     (w_code)
    );
    // Lane arrays carry no reset; only the INIT sweep clears them.
    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        always_ff @(posedge i_clk)
            if (w_we[l]) r_mem[w_widx] <= w_wd[8*l +: 8];
        assign w_rword[8*l +: 8] = r_mem[w_idx];
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else if (r_state == S_INIT) begin
            r_cnt <= r_cnt + AW'(1);
            if (CLEAR_ON_RESET == 0 || r_cnt == AW'(DEPTH_WORDS - 1)) begin
                r_state <= S_READY;
                r_ready <= 1'b1;
            end
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v <= '{default: 1'b0};
            r_d <= '{default: 32'h0};
            r_c <= '{default: MEM_FAULT_NONE};
        end else begin
            r_v[0] <= w_acc;
            r_v[1] <= r_v[0];
            r_d[0] <= w_acc ? w_rdata : 32'h0;
            r_d[1] <= r_d[0];
            r_c[0] <= w_acc ? w_code : MEM_FAULT_NONE;
            r_c[1] <= r_c[0];
        end
    end
    assign bus.req_ready      = r_ready;
    assign bus.init_done      = r_ready;
    assign bus.rsp_valid      = r_v[READ_LATENCY-1];
    assign bus.rsp_data       = r_d[READ_LATENCY-1];
    assign bus.rsp_fault_code = r_c[READ_LATENCY-1];
    assign bus.rsp_fault      = r_c[READ_LATENCY-1] != MEM_FAULT_NONE;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed checks of data_memory_ctrl at latency 1 (u0) and latency 2 (u1).
module tb_data_memory_ctrl;
    import data_memory_ctrl_pkg::*;
    typedef struct {
        logic        we;
        logic [1:0]  fi;
        logic [2:0]  fo;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] er;
        logic [1:0]  ec;
        string       nm;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_pass = 0;
    int          n_tot = 0;
    logic        v, f;
    logic [31:0] rd;
    logic [1:0]  c;
    always #5 clk = ~clk;
    data_memory_ctrl_if bus0 ();
    data_memory_ctrl_if bus1 ();
    data_memory_ctrl #(.DEPTH_WORDS(16), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
    data_memory_ctrl #(.DEPTH_WORDS(16), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

    task automatic idle();
        bus0.req_valid = 0; bus0.req_we = 0; bus0.req_func_in = 0; bus0.req_func_out = 0;
        bus0.req_addr = 0; bus0.req_wdata = 0;
        bus1.req_valid = 0; bus1.req_we = 0; bus1.req_func_in = 0; bus1.req_func_out = 0;
        bus1.req_addr = 0; bus1.req_wdata = 0;
    endtask

    task automatic acc0(input logic we, input logic [1:0] fi, input logic [2:0] fo,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic ov, output logic [31:0] ord, output logic of, output logic [1:0] oc);
        bus0.req_valid = 1; bus0.req_we = we; bus0.req_func_in = fi; bus0.req_func_out = fo;
        bus0.req_addr = a; bus0.req_wdata = d;
        @(posedge clk); #1;
        ov = bus0.rsp_valid; ord = bus0.rsp_data; of = bus0.rsp_fault; oc = bus0.rsp_fault_code;
        bus0.req_valid = 0;
    endtask

    task automatic count_init(input string nm);
        int n = 0;
        while (!bus0.req_ready && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        n_tot++;
        if (n !== 16) $display("FAIL %s: ready-low cycles %0d, required 16", nm, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        idle();
        repeat (3) @(posedge clk);
        #1;
        n_tot++;
        if ({bus0.req_ready, bus0.init_done, bus0.rsp_valid, bus0.rsp_fault} !== 4'b0)
            $display("FAIL reset_outputs: rdy/done/vld/flt=%b required 0000",
                     {bus0.req_ready, bus0.init_done, bus0.rsp_valid, bus0.rsp_fault});
        else n_pass++;
        n_tot++;
        if (bus0.rsp_data !== 32'h0) $display("FAIL reset_data: got %h required 0", bus0.rsp_data);
        else n_pass++;
        rst_n = 1;
        count_init("init_first");
        n_tot++;
        if (bus0.init_done !== 1'b1) $display("FAIL init_done: got %b required 1", bus0.init_done);
        else n_pass++;
        acc0(0, 0, MEM_LW, 32'h3C, 0, v, rd, f, c);
        n_tot++;
        if ({v, f, c, rd} !== {1'b1, 1'b0, 2'd0, 32'h0})
            $display("FAIL lw_3c_cleared: v=%b f=%b c=%0d d=%h required v=1 f=0 c=0 d=00000000", v, f, c, rd);
        else n_pass++;
    endtask

    task automatic test_load_ext();
        vec_t t [6];
        t = '{'{1, MEM_SW, 0, 32'h8, 32'hDEADBEEF, 32'h0, 2'd0, "sw_8"},
              '{0, 0, MEM_LB,  32'h9, 0, 32'hFFFFFFBE, 2'd0, "lb_9"},
              '{0, 0, MEM_LBU, 32'hB, 0, 32'h000000DE, 2'd0, "lbu_b"},
              '{0, 0, MEM_LH,  32'hA, 0, 32'hFFFFDEAD, 2'd0, "lh_a"},
              '{0, 0, MEM_LHU, 32'h8, 0, 32'h0000BEEF, 2'd0, "lhu_8"},
              '{0, 0, MEM_LW,  32'h8, 0, 32'hDEADBEEF, 2'd0, "lw_8"}};
        for (int i = 0; i < 6; i++) begin
            acc0(t[i].we, t[i].fi, t[i].fo, t[i].a, t[i].d, v, rd, f, c);
            n_tot++;
            if ({v, f, c, rd} !== {1'b1, t[i].ec != 2'd0, t[i].ec, t[i].er})
                $display("FAIL %s: v=%b f=%b c=%0d d=%h required v=1 c=%0d d=%h", t[i].nm, v, f, c, rd, t[i].ec, t[i].er);
            else n_pass++;
        end
    endtask

    task automatic test_partial_store();
        vec_t t [7];
        t = '{'{1, MEM_SB, 0, 32'hA, 32'h00000055, 32'h0, 2'd0, "sb_a"},
              '{0, 0, MEM_LW, 32'h8, 0, 32'hDE55BEEF, 2'd0, "lw_8_after_sb"},
              '{1, MEM_SH, 0, 32'h5, 32'h0000FFFF, 32'h0, 2'd1, "sh_5_misalign"},
              '{0, 0, MEM_LW, 32'h4, 0, 32'h00000000, 2'd0, "lw_4_unchanged"},
              '{1, MEM_SH, 0, 32'h6, 32'hABCD1234, 32'h0, 2'd0, "sh_6"},
              '{0, 0, MEM_LW, 32'h4, 0, 32'h12340000, 2'd0, "lw_4_after_sh"},
              '{0, 0, MEM_LH, 32'h6, 0, 32'h00001234, 2'd0, "lh_6"}};
        for (int i = 0; i < 7; i++) begin
            acc0(t[i].we, t[i].fi, t[i].fo, t[i].a, t[i].d, v, rd, f, c);
            n_tot++;
            if ({v, f, c, rd} !== {1'b1, t[i].ec != 2'd0, t[i].ec, t[i].er})
                $display("FAIL %s: v=%b f=%b c=%0d d=%h required v=1 c=%0d d=%h", t[i].nm, v, f, c, rd, t[i].ec, t[i].er);
            else n_pass++;
        end
    endtask

    task automatic test_faults();
        vec_t t [8];
        t = '{'{0, 0, MEM_LW, 32'h40, 0, 32'h0, 2'd2, "lw_40_range"},
              '{0, 0, 3'd3, 32'h0, 0, 32'h0, 2'd3, "lfunc3"},
              '{1, 2'd3, 0, 32'h0, 32'hFFFFFFFF, 32'h0, 2'd3, "sfunc3"},
              '{0, 0, MEM_LW, 32'h0, 0, 32'h0, 2'd0, "lw_0_unwritten"},
              '{0, 0, MEM_LW, 32'h2, 0, 32'h0, 2'd1, "lw_2_misalign"},
              '{0, 0, MEM_LHU, 32'h3, 0, 32'h0, 2'd1, "lhu_3_misalign"},
              '{0, 0, 3'd7, 32'h40, 0, 32'h0, 2'd2, "range_over_func"},
              '{0, 0, MEM_LW, 32'hFFFFFFFC, 0, 32'h0, 2'd2, "lw_top_range"}};
        for (int i = 0; i < 8; i++) begin
            acc0(t[i].we, t[i].fi, t[i].fo, t[i].a, t[i].d, v, rd, f, c);
            n_tot++;
            if ({v, f, c, rd} !== {1'b1, t[i].ec != 2'd0, t[i].ec, t[i].er})
                $display("FAIL %s: v=%b f=%b c=%0d d=%h required v=1 c=%0d d=%h", t[i].nm, v, f, c, rd, t[i].ec, t[i].er);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        vec_t t [5];
        t = '{'{1, MEM_SW, 0, 32'hC, 32'h12345678, 32'h0, 2'd0, "b2b_sw_c"},
              '{0, 0, MEM_LW, 32'hC, 0, 32'h12345678, 2'd0, "b2b_lw_c"},
              '{1, MEM_SB, 0, 32'hF, 32'h000000AA, 32'h0, 2'd0, "b2b_sb_f"},
              '{0, 0, MEM_LBU, 32'hF, 0, 32'h000000AA, 2'd0, "b2b_lbu_f"},
              '{0, 0, MEM_LW, 32'hC, 0, 32'hAA345678, 2'd0, "b2b_lw_c2"}};
        for (int i = 0; i < 5; i++) begin
            acc0(t[i].we, t[i].fi, t[i].fo, t[i].a, t[i].d, v, rd, f, c);
            n_tot++;
            if ({v, f, c, rd} !== {1'b1, t[i].ec != 2'd0, t[i].ec, t[i].er})
                $display("FAIL %s: v=%b f=%b c=%0d d=%h required v=1 c=%0d d=%h", t[i].nm, v, f, c, rd, t[i].ec, t[i].er);
            else n_pass++;
        end
    endtask

    task automatic test_latency2();
        for (int i = 0; i < 8; i++) begin
            bus1.req_valid = 1; bus1.req_we = 1; bus1.req_func_in = MEM_SW;
            bus1.req_addr = 32'(4 * i); bus1.req_wdata = 32'hC0DE0000 | 32'(i);
            @(posedge clk); #1;
        end
        bus1.req_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int j = 0; j < 10; j++) begin
            bus1.req_valid = (j < 8); bus1.req_we = 0; bus1.req_func_out = MEM_LW;
            bus1.req_addr = 32'(4 * j);
            @(posedge clk); #1;
            n_tot++;
            if (bus1.rsp_valid !== (j >= 1 && j <= 8))
                $display("FAIL lat2_valid_%0d: got %b required %b", j, bus1.rsp_valid, (j >= 1 && j <= 8));
            else n_pass++;
            if (j >= 1 && j <= 8) begin
                n_tot++;
                if (bus1.rsp_data !== (32'hC0DE0000 | 32'(j - 1)))
                    $display("FAIL lat2_data_%0d: got %h required %h", j, bus1.rsp_data, 32'hC0DE0000 | 32'(j - 1));
                else n_pass++;
            end
        end
        bus1.req_valid = 0;
    endtask

    task automatic test_reset_mid();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (5) @(posedge clk);
        #1;
        n_tot++;
        if (bus0.req_ready !== 1'b0) $display("FAIL mid_init_ready: got %b required 0", bus0.req_ready);
        else n_pass++;
        rst_n = 0;
        #1;
        rst_n = 1;
        count_init("init_restart");
        acc0(1, MEM_SW, 0, 32'h8, 32'h11111111, v, rd, f, c);
        bus0.req_valid = 1; bus0.req_we = 0; bus0.req_func_out = MEM_LW; bus0.req_addr = 32'h8;
        @(posedge clk); #1;
        n_tot++;
        if ({bus0.rsp_valid, bus0.rsp_data} !== {1'b1, 32'h11111111})
            $display("FAIL burst_rsp: v=%b d=%h required v=1 d=11111111", bus0.rsp_valid, bus0.rsp_data);
        else n_pass++;
        rst_n = 0;
        #1;
        n_tot++;
        if ({bus0.rsp_valid, bus0.rsp_data, bus1.rsp_valid} !== {1'b0, 32'h0, 1'b0})
            $display("FAIL reset_flush: v0=%b d0=%h v1=%b required 0 0 0", bus0.rsp_valid, bus0.rsp_data, bus1.rsp_valid);
        else n_pass++;
        bus0.req_valid = 0;
        @(posedge clk); #1;
        rst_n = 1;
        count_init("init_after_burst");
        n_tot++;
        if (bus0.rsp_valid !== 1'b0) $display("FAIL no_stale_rsp: got %b required 0", bus0.rsp_valid);
        else n_pass++;
        acc0(0, 0, MEM_LW, 32'h8, 0, v, rd, f, c);
        n_tot++;
        if ({v, f, rd} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL recleared_lw_8: v=%b f=%b d=%h required v=1 f=0 d=00000000", v, f, rd);
        else n_pass++;
    endtask

    initial begin
        idle();
        test_reset();
        test_load_ext();
        test_partial_store();
        test_faults();
        test_back_to_back();
        test_latency2();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
